seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment code table and leading-zero helper for the seven-segment scan driver
package seg7_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low a..g codes (bit0 = a) for hex digits 0..F.
  localparam logic [6:0] SEG_CODES [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Leading-zero blank-mask bit for one digit: set when every nibble from the top
  // digit down to this one is zero. Digit 0 always stays lit.
  function automatic logic lz_mask_bit(input logic [4*MAX_DIGITS-1:0] nibbles,
                                       input int digit, input int digits);
    logic all_zero;
    all_zero = (digit > 0);
    for (int j = MAX_DIGITS - 1; j >= 1; j--) begin
      if (j >= digit && j < digits && nibbles[4*j +: 4] != 4'h0) begin
        all_zero = 1'b0;
      end
    end
    return all_zero;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to active-low segment lookup
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_CODES[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed multi-digit seven-segment scan driver with frame-boundary commit
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  input  logic [DIGITS-1:0]     load_blink,
  input  logic                  load_lz,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]        SEG_IDLE = ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic              DP_IDLE  = ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                frame_done_q, frame_done_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                pend_full_q, pend_full_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [DIGITS-1:0]   pend_blink_q, pend_blink_d;
  logic                pend_lz_q, pend_lz_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]   shd_blank_q, shd_blank_d;
  logic [DIGITS-1:0]   shd_blink_q, shd_blink_d;
  logic                ready_q, ready_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick, wrap, accept, dead, dark;
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg_n, seg_raw_n;
  logic                dp_raw_n;
  logic [DIGITS-1:0]   an_onehot, lz_mask;

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .seg_n  (dec_seg_n)
  );

  always_comb begin
    tick      = (presc_q == PW'(SCAN_DIV - 1));
    wrap      = tick && (idx_q == IW'(DIGITS - 1));
    accept    = load_valid && !pend_full_q;
    dead      = (presc_q < PW'(DEAD_CYC));
    dark      = shd_blank_q[idx_q] || (shd_blink_q[idx_q] && blink_phase_q);
    cur_nib   = shd_data_q[{idx_q, 2'b00} +: 4];

    for (int i = 0; i < DIGITS; i++) begin
      lz_mask[i] = lz_mask_bit((4*MAX_DIGITS)'(pend_data_q), i, DIGITS);
    end

    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    frame_done_d  = wrap;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    pend_full_d   = pend_full_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_blink_d  = pend_blink_q;
    pend_lz_d     = pend_lz_q;
    shd_data_d    = shd_data_q;
    shd_dp_d      = shd_dp_q;
    shd_blank_d   = shd_blank_q;
    shd_blink_d   = shd_blink_q;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    if (wrap) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Ready is low whenever pending is full, so accept and commit never collide.
    if (wrap && pend_full_q) begin
      shd_data_d  = pend_data_q;
      shd_dp_d    = pend_dp_q;
      shd_blink_d = pend_blink_q;
      shd_blank_d = pend_blank_q | (pend_lz_q ? lz_mask : '0);
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_data_d  = load_data;
      pend_dp_d    = load_dp;
      pend_blank_d = load_blank;
      pend_blink_d = load_blink;
      pend_lz_d    = load_lz;
      pend_full_d  = 1'b1;
    end

    ready_d = !pend_full_d;

    an_onehot = '0;
    if (!dead) begin
      an_onehot[idx_q] = 1'b1;
    end
    seg_raw_n = (dead || dark) ? SEG_OFF : dec_seg_n;
    dp_raw_n  = (dead || dark) ? 1'b1 : !shd_dp_q[idx_q];

    seg_d = ACTIVE_LOW ? seg_raw_n : ~seg_raw_n;
    dp_d  = ACTIVE_LOW ? dp_raw_n : !dp_raw_n;
    an_d  = ACTIVE_LOW ? ~an_onehot : an_onehot;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_done_q  <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_full_q   <= 1'b0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_blink_q  <= '0;
      pend_lz_q     <= 1'b0;
      shd_data_q    <= '0;
      shd_dp_q      <= '0;
      shd_blank_q   <= '1;
      shd_blink_q   <= '0;
      ready_q       <= 1'b1;
      seg_q         <= SEG_IDLE;
      dp_q          <= DP_IDLE;
      an_q          <= AN_IDLE;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_done_q  <= frame_done_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_full_q   <= pend_full_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_blink_q  <= pend_blink_d;
      pend_lz_q     <= pend_lz_d;
      shd_data_q    <= shd_data_d;
      shd_dp_q      <= shd_dp_d;
      shd_blank_q   <= shd_blank_d;
      shd_blink_q   <= shd_blink_d;
      ready_q       <= ready_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign load_ready = ready_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - bench for seg7_scan_driver against a cycle-count based display model
module tb_seg7_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 4;
  localparam int DEAD_CYC     = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = SCAN_DIV * DIGITS;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  load_blank = '0;
  logic [3:0]  load_blink = '0;
  logic        load_lz = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_done;

  always #5 clock = ~clock;

  seg7_scan_driver #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .DEAD_CYC     (DEAD_CYC),
    .BLINK_FRAMES (BLINK_FRAMES),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .load_blink (load_blink),
    .load_lz    (load_lz),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Model state: pending buffer, committed frame, expected outputs for the current cycle.
  logic        p_full;
  logic [15:0] p_data;
  logic [3:0]  p_dp, p_blank, p_blink;
  logic        p_lz;
  logic [3:0]  sh_nib [DIGITS];
  logic [3:0]  sh_dp, sh_blank, sh_blink;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd, e_segv;
  logic        last_acc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    p_full   = 1'b0;
    sh_blank = 4'hF;
    sh_blink = 4'h0;
    sh_dp    = 4'h0;
    for (int d = 0; d < DIGITS; d++) sh_nib[d] = 4'h0;
    e_an   = 4'hF;
    e_seg  = 7'h7F;
    e_dp   = 1'b1;
    e_fd   = 1'b0;
    e_segv = 1'b1;
  endtask

  // One clock cycle: check this cycle's outputs, predict the next, drive inputs, advance.
  task automatic cycle(input logic v, input logic [15:0] data, input logic [3:0] dp,
                       input logic [3:0] blank, input logic [3:0] blink, input logic lz);
    int  ph, d, bl;
    logic dk;
    check_eq("an_out", an_out, e_an);
    if (e_segv) begin
      check_eq("seg_out", seg_out, e_seg);
      check_eq("dp_out", dp_out, e_dp);
    end
    check_eq("frame_done", frame_done, e_fd);
    check_eq("load_ready", load_ready, !p_full);

    ph = k % SCAN_DIV;
    d  = (k / SCAN_DIV) % DIGITS;
    bl = (k / FRAME / BLINK_FRAMES) % 2;
    dk = sh_blank[d] || (sh_blink[d] && bl == 1);
    e_segv = (ph >= DEAD_CYC);
    e_an   = e_segv ? ~(4'b0001 << d) : 4'hF;
    e_seg  = (!e_segv || dk) ? 7'h7F : HEX_TAB[sh_nib[d]];
    e_dp   = (!e_segv || dk) ? 1'b1 : !sh_dp[d];
    e_fd   = (k % FRAME == FRAME - 1);

    load_valid = v;
    load_data  = data;
    load_dp    = dp;
    load_blank = blank;
    load_blink = blink;
    load_lz    = lz;
    last_acc   = v && !p_full;

    if (k % FRAME == FRAME - 1 && p_full) begin
      for (int n = 0; n < DIGITS; n++) sh_nib[n] = p_data[4*n +: 4];
      sh_dp    = p_dp;
      sh_blink = p_blink;
      sh_blank = p_blank;
      if (p_lz) begin
        for (int n = DIGITS - 1; n >= 1; n--) begin
          if (sh_nib[n] != 4'h0) break;
          sh_blank[n] = 1'b1;
        end
      end
      p_full = 1'b0;
    end else if (last_acc) begin
      p_full  = 1'b1;
      p_data  = data;
      p_dp    = dp;
      p_blank = blank;
      p_blink = blink;
      p_lz    = lz;
    end

    @(posedge clock);
    k++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic offer(input logic [15:0] data, input logic [3:0] dp, input logic [3:0] blank,
                       input logic [3:0] blink, input logic lz);
    last_acc = 1'b0;
    for (int n = 0; n < 64 && !last_acc; n++) cycle(1'b1, data, dp, blank, blink, lz);
    check_eq("offer_accepted", last_acc, 1'b1);
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] r;
    for (int n = 0; n < 4; n++) r[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    return r;
  endfunction

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(40);

    offer(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
    idle(40);

    offer(16'h0070, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(40);

    offer(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0);
    offer(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0);
    idle(40);

    offer(16'h0008, 4'h0, 4'h0, 4'b0001, 1'b0);
    idle(140);

    offer(16'h0000, 4'b1010, 4'h0, 4'h0, 1'b1);
    idle(36);

    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) == 0, rnd_data(), 4'($urandom), 4'($urandom_range(0, 1) ? $urandom : 0),
            4'($urandom), 1'($urandom));
    end
    idle(20);

    while (k % FRAME != 2) cycle(1'b0, 16'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    offer(16'h5A5A, 4'h0, 4'h0, 4'h0, 1'b0);
    idle(3);
    check_eq("ready_before_reset", load_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_an", an_out, 4'hF);
    check_eq("rst_seg", seg_out, 7'h7F);
    check_eq("rst_dp", dp_out, 1'b1);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_ready", load_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
